// File: rtl/shreg_tx_pkg.sv
// Shared types and sizing helpers for the serial transmit controller.
// SHREG_TX_PARITY_EN adds one even-parity bit to every frame.
package shreg_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

`ifdef SHREG_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Wide enough for the bit count of the longest frame and for the gap count.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width + 1 > gap) ? width + 1 : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/shreg_tx_ctrl_core.sv
// WIDTH-bit parallel-load / shift-left register; shift wins over load.
module shreg_core
  import shreg_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic             i_sin,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sin};
    end else if (i_load) begin
      r_data <= i_pdata;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/shreg_tx_ctrl.sv
// Serialises WIDTH-bit words MSB-first with valid/last framing and GAP idle cycles.
// SHREG_TX_PARITY_EN appends an even-parity bit as the last frame bit.
module shreg_tx_ctrl
  import shreg_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  input  logic             i_hold,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  output logic             o_ser_last,
  output logic             o_busy
);

  localparam int FLEN = frame_len(WIDTH);
  localparam int CW   = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_load;
  logic            w_shift;
  logic            w_sin;
  logic            w_msb;
  logic            w_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef SHREG_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^i_in_data;
    end else begin
      r_parity <= r_parity;
    end
  end

  // Parity enters the LSB on the first shift and reaches the MSB right after the data bits.
  assign w_sin = r_parity & (r_cnt == '0);
`else
  assign w_sin = 1'b0;
`endif

  assign w_last = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (!i_hold) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_shift = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  shreg_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_pdata (i_in_data),
    .i_sin   (w_sin),
    .o_msb   (w_msb)
  );

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_ser_valid = (r_state == ST_SHIFT) && !i_hold;
  assign o_ser_last  = o_ser_valid && w_last;
  assign o_ser_out   = w_msb;

endmodule

// File: tb/tb_shreg_tx_ctrl.sv
// Bench for shreg_tx_ctrl: two instances (GAP=0 and GAP=2) share stimulus and are
// checked every cycle against a frame-queue model, plus directed literal checks.
module tb_shreg_tx_ctrl;

  localparam int W = 4;
`ifdef SHREG_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] S1_EXP = 16'b10111;
  localparam logic [15:0] S2_EXP = 16'b1010001010;
  localparam logic [15:0] S3_EXP = 16'b11000;
  localparam logic [15:0] S4_EXP = 16'b00000;
  localparam logic [15:0] S5_EXP = 16'b01100;
  localparam logic [15:0] S6_EXP = 16'b10010;
`else
  localparam int PB = 0;
  localparam logic [15:0] S1_EXP = 16'b1011;
  localparam logic [15:0] S2_EXP = 16'b10100101;
  localparam logic [15:0] S3_EXP = 16'b1100;
  localparam logic [15:0] S4_EXP = 16'b0000;
  localparam logic [15:0] S5_EXP = 16'b0110;
`endif
  localparam int FLEN = W + PB;
  localparam int GAPS [2] = '{0, 2};

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [1:0]   rdy, sv, so, sl, bz;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int hs_cyc = 0;

  shreg_tx_ctrl #(.WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(rdy[0]), .i_hold(hold), .o_ser_out(so[0]),
    .o_ser_valid(sv[0]), .o_ser_last(sl[0]), .o_busy(bz[0])
  );

  shreg_tx_ctrl #(.WIDTH(W), .GAP(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(rdy[1]), .i_hold(hold), .o_ser_out(so[1]),
    .o_ser_valid(sv[1]), .o_ser_last(sl[1]), .o_busy(bz[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each instance holds the remaining frame bits and the remaining gap cycles.
  logic [15:0] m_frame [2];
  int          m_left [2];
  int          m_gap [2];

  function automatic logic [15:0] frame_of(input logic [W-1:0] d);
`ifdef SHREG_TX_PARITY_EN
    return 16'({d, ^d});
`else
    return 16'(d);
`endif
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        m_left[d]  <= 0;
        m_gap[d]   <= 0;
        m_frame[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_left[d] == 0 && m_gap[d] == 0) begin
          if (in_valid) begin
            m_frame[d] <= frame_of(in_data);
            m_left[d]  <= FLEN;
          end
        end else if (m_left[d] > 0) begin
          if (!hold) begin
            m_left[d] <= m_left[d] - 1;
            if (m_left[d] == 1) m_gap[d] <= GAPS[d];
          end
        end else begin
          m_gap[d] <= m_gap[d] - 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stream log: bits seen with ser_valid, count and cycle of ser_last.
  logic [31:0] s_bits [2] = '{32'd0, 32'd0};
  int          s_len [2]  = '{0, 0};
  int          l_cnt [2]  = '{0, 0};
  int          l_cyc [2]  = '{0, 0};

  initial begin
    logic er, ev, eo, el;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        er = (m_left[d] == 0 && m_gap[d] == 0);
        ev = (m_left[d] > 0) && !hold;
        eo = (m_left[d] > 0) ? m_frame[d][m_left[d]-1] : 1'b0;
        el = ev && (m_left[d] == 1);
        check($sformatf("in_ready[%0d]", d), int'(rdy[d]), int'(er));
        check($sformatf("ser_valid[%0d]", d), int'(sv[d]), int'(ev));
        check($sformatf("ser_out[%0d]", d), int'(so[d]), int'(eo));
        check($sformatf("ser_last[%0d]", d), int'(sl[d]), int'(el));
        check($sformatf("busy[%0d]", d), int'(bz[d]), int'(!er));
        if (sv[d]) begin
          s_bits[d] = {s_bits[d][30:0], so[d]};
          s_len[d]++;
        end
        if (sl[d]) begin
          l_cnt[d]++;
          l_cyc[d] = cyc;
        end
      end
    end
  end

  int b_len [2];
  int b_l [2];

  task automatic mark();
    for (int d = 0; d < 2; d++) begin
      b_len[d] = s_len[d];
      b_l[d]   = l_cnt[d];
    end
  endtask

  task automatic check_stream(input string name, input int d, input int n, input logic [15:0] exp);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    check({name, "_len"}, s_len[d] - b_len[d], n);
    check({name, "_bits"}, int'(s_bits[d] & mask), int'({16'd0, exp}));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (&rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_idle: in_ready=%b, required 11 within 60 cycles", rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs_cyc   = cyc;
  endtask

  initial begin
    int n, nhs, ngap, t1, t2;
    logic hs;

    #12;
    check("rst_ready", int'(rdy), 3);
    check("rst_valid", int'(sv), 0);
    check("rst_out", int'(so), 0);
    check("rst_last", int'(sl), 0);
    check("rst_busy", int'(bz), 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_idle();

    // Single word on the GAP=0 instance.
    mark();
    send(4'b1011);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy[0]) begin
        n = i;
        break;
      end
    end
    check("s1_ready_return", n, 5 + PB);
    check("s1_last_pos", l_cyc[0] - hs_cyc, 3 + PB);
    wait_idle();
    check_stream("s1", 0, FLEN, S1_EXP);
    check("s1_last_cnt", l_cnt[0] - b_l[0], 1);

    // Back-to-back words with in_valid held; timing checked on the GAP=2 instance.
    mark();
    in_data  = 4'hA;
    in_valid = 1'b1;
    nhs = 0; ngap = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 40 && nhs < 2; i++) begin
      @(negedge clk);
      hs = rdy[1] && in_valid;
      if (bz[1] && !sv[1]) ngap++;
      @(posedge clk);
      #1;
      if (hs) begin
        nhs++;
        if (nhs == 1) begin
          t1 = cyc;
          in_data = 4'h5;
        end else begin
          t2 = cyc;
          in_valid = 1'b0;
        end
      end
    end
    check("s2_handshakes", nhs, 2);
    check("s2_period", t2 - t1, 7 + PB);
    check("s2_gap_cycles", ngap, 2);
    wait_idle();
    check_stream("s2", 1, 2 * FLEN, S2_EXP);
    check("s2_last_cnt", l_cnt[1] - b_l[1], 2);

    // Hold for 3 cycles over the second bit.
    mark();
    send(4'b1100);
    @(posedge clk);
    #1;
    hold = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    wait_idle();
    check_stream("s3", 0, FLEN, S3_EXP);
    check("s3_last_pos", l_cyc[0] - hs_cyc, 6 + PB);
    check("s3_last_cnt", l_cnt[0] - b_l[0], 1);

    // in_valid while busy is ignored.
    mark();
    send(4'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    @(negedge clk);
    check("s4_ready_busy", int'(rdy), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    wait_idle();
    check_stream("s4", 0, FLEN, S4_EXP);
    check("s4_last_cnt", l_cnt[0] - b_l[0], 1);

    // Reset after two bits aborts the frame.
    mark();
    send(4'hF);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    check("s5_rst_valid", int'(sv), 0);
    check("s5_rst_busy", int'(bz), 0);
    check("s5_rst_out", int'(so), 0);
    check("s5_rst_ready", int'(rdy), 3);
    @(negedge clk);
    rstn = 1'b1;
    check_stream("s5_abort", 0, 2, 16'b11);
    check("s5_abort_last", l_cnt[0] - b_l[0], 0);
    wait_idle();
    mark();
    send(4'b0110);
    wait_idle();
    check_stream("s5_after", 0, FLEN, S5_EXP);
    check("s5_after_last", l_cnt[0] - b_l[0], 1);

`ifdef SHREG_TX_PARITY_EN
    // Zero-parity word.
    mark();
    send(4'b1001);
    wait_idle();
    check_stream("s6", 0, FLEN, S6_EXP);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
